// File: rtl/alu_181_checker.sv
// Checker for a 74181-style ALU: recomputes the expected response for each stimulus/response
// pair, then counts, flags and captures mismatches.
module alu_181_checker #(
  parameter int unsigned WIDTH   = 16,
  parameter logic [15:0] ERR_SAT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       op_in,
  input  logic             mode_in,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] dut_out,
  input  logic             dut_carry,
  input  logic             dut_equal,
  output logic             mismatch,
  output logic [31:0]      check_count,
  output logic [15:0]      err_count,
  output logic             failed,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_exp,
  output logic [WIDTH-1:0] fail_got,
  output logic [3:0]       fail_op,
  output logic             fail_mode,
  output logic             fail_cin
);

  typedef enum logic [0:0] {StPass, StFail} state_e;
  state_e state_q;

  logic             s1_valid_q, s1_mode_q, s1_cin_q, s1_carry_q, s1_equal_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_out_q;
  logic [3:0]       s1_op_q;

  logic             s2_valid_q, s2_fail_q, s2_mode_q, s2_cin_q;
  logic [WIDTH-1:0] s2_a_q, s2_b_q, s2_exp_q, s2_got_q;
  logic [3:0]       s2_op_q;

  logic             mismatch_q, fail_mode_q, fail_cin_q;
  logic [31:0]      check_q;
  logic [15:0]      err_q;
  logic [WIDTH-1:0] fail_a_q, fail_b_q, fail_exp_q, fail_got_q;
  logic [3:0]       fail_op_q;

  logic [WIDTH-1:0] ones, x_d, y_d, exp_res_d;
  logic [WIDTH:0]   sum_d;
  logic             exp_carry_d, exp_equal_d, fail_d;

  assign ones = '1;

  always_comb begin
    x_d         = '0;
    y_d         = '0;
    sum_d       = '0;
    exp_res_d   = '0;
    exp_carry_d = 1'b0;
    if (s1_mode_q) begin
      case (s1_op_q)
        4'h0: exp_res_d = ~s1_a_q;
        4'h1: exp_res_d = ~(s1_a_q | s1_b_q);
        4'h2: exp_res_d = ~s1_a_q & s1_b_q;
        4'h3: exp_res_d = '0;
        4'h4: exp_res_d = ~(s1_a_q & s1_b_q);
        4'h5: exp_res_d = ~s1_b_q;
        4'h6: exp_res_d = s1_a_q ^ s1_b_q;
        4'h7: exp_res_d = s1_a_q & ~s1_b_q;
        4'h8: exp_res_d = ~s1_a_q | s1_b_q;
        4'h9: exp_res_d = ~(s1_a_q ^ s1_b_q);
        4'hA: exp_res_d = s1_b_q;
        4'hB: exp_res_d = s1_a_q & s1_b_q;
        4'hC: exp_res_d = ones;
        4'hD: exp_res_d = s1_a_q | ~s1_b_q;
        4'hE: exp_res_d = s1_a_q | s1_b_q;
        default: exp_res_d = s1_a_q;
      endcase
    end else begin
      // Arithmetic ops are all X + Y + cin with op-dependent operand shaping.
      case (s1_op_q)
        4'h0: begin x_d = s1_a_q;              y_d = '0;                 end
        4'h1: begin x_d = s1_a_q | s1_b_q;     y_d = '0;                 end
        4'h2: begin x_d = s1_a_q | ~s1_b_q;    y_d = '0;                 end
        4'h3: begin x_d = '0;                  y_d = ones;               end
        4'h4: begin x_d = s1_a_q;              y_d = s1_a_q & ~s1_b_q;   end
        4'h5: begin x_d = s1_a_q | s1_b_q;     y_d = s1_a_q & ~s1_b_q;   end
        4'h6: begin x_d = s1_a_q;              y_d = ~s1_b_q;            end
        4'h7: begin x_d = s1_a_q & ~s1_b_q;    y_d = ones;               end
        4'h8: begin x_d = s1_a_q;              y_d = s1_a_q & s1_b_q;    end
        4'h9: begin x_d = s1_a_q;              y_d = s1_b_q;             end
        4'hA: begin x_d = s1_a_q | ~s1_b_q;    y_d = s1_a_q & s1_b_q;    end
        4'hB: begin x_d = s1_a_q & s1_b_q;     y_d = ones;               end
        4'hC: begin x_d = s1_a_q;              y_d = s1_a_q;             end
        4'hD: begin x_d = s1_a_q | s1_b_q;     y_d = s1_a_q;             end
        4'hE: begin x_d = s1_a_q | ~s1_b_q;    y_d = s1_a_q;             end
        default: begin x_d = s1_a_q;           y_d = ones;               end
      endcase
      sum_d       = {1'b0, x_d} + {1'b0, y_d} + {{WIDTH{1'b0}}, s1_cin_q};
      exp_res_d   = sum_d[WIDTH-1:0];
      exp_carry_d = sum_d[WIDTH];
    end
    exp_equal_d = &exp_res_d;
    fail_d      = (exp_res_d != s1_out_q) | (exp_carry_d != s1_carry_q) |
                  (exp_equal_d != s1_equal_q);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      // rst and clear reset identical state; rst simply outranks clear.
      state_q     <= StPass;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      mismatch_q  <= 1'b0;
      check_q     <= '0;
      err_q       <= '0;
      fail_a_q    <= '0;
      fail_b_q    <= '0;
      fail_exp_q  <= '0;
      fail_got_q  <= '0;
      fail_op_q   <= '0;
      fail_mode_q <= 1'b0;
      fail_cin_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_out_q    <= '0;
      s1_op_q     <= '0;
      s1_mode_q   <= 1'b0;
      s1_cin_q    <= 1'b0;
      s1_carry_q  <= 1'b0;
      s1_equal_q  <= 1'b0;
      s2_fail_q   <= 1'b0;
      s2_a_q      <= '0;
      s2_b_q      <= '0;
      s2_exp_q    <= '0;
      s2_got_q    <= '0;
      s2_op_q     <= '0;
      s2_mode_q   <= 1'b0;
      s2_cin_q    <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q     <= a_in;
        s1_b_q     <= b_in;
        s1_out_q   <= dut_out;
        s1_op_q    <= op_in;
        s1_mode_q  <= mode_in;
        s1_cin_q   <= carry_in;
        s1_carry_q <= dut_carry;
        s1_equal_q <= dut_equal;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_fail_q <= fail_d;
        s2_a_q    <= s1_a_q;
        s2_b_q    <= s1_b_q;
        s2_exp_q  <= exp_res_d;
        s2_got_q  <= s1_out_q;
        s2_op_q   <= s1_op_q;
        s2_mode_q <= s1_mode_q;
        s2_cin_q  <= s1_cin_q;
      end
      mismatch_q <= s2_valid_q & s2_fail_q;
      if (s2_valid_q) begin
        check_q <= check_q + 32'd1;
        if (s2_fail_q) begin
          if (err_q < ERR_SAT) err_q <= err_q + 16'd1;
          if (state_q == StPass) begin
            state_q     <= StFail;
            fail_a_q    <= s2_a_q;
            fail_b_q    <= s2_b_q;
            fail_exp_q  <= s2_exp_q;
            fail_got_q  <= s2_got_q;
            fail_op_q   <= s2_op_q;
            fail_mode_q <= s2_mode_q;
            fail_cin_q  <= s2_cin_q;
          end
        end
      end
    end
  end

  assign mismatch    = mismatch_q;
  assign check_count = check_q;
  assign err_count   = err_q;
  assign failed      = (state_q == StFail);
  assign fail_a      = fail_a_q;
  assign fail_b      = fail_b_q;
  assign fail_exp    = fail_exp_q;
  assign fail_got    = fail_got_q;
  assign fail_op     = fail_op_q;
  assign fail_mode   = fail_mode_q;
  assign fail_cin    = fail_cin_q;

endmodule

// File: tb/tb_alu_181_checker.sv
// Bench for alu_181_checker: a reference ALU model feeds a latency-matched scoreboard queue.
module tb_alu_181_checker;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clear, in_valid, mode_in, carry_in, dut_carry, dut_equal;
  logic [W-1:0]  a_in, b_in, dut_out;
  logic [3:0]    op_in;
  logic          mismatch, failed, fail_mode, fail_cin;
  logic [31:0]   check_count;
  logic [15:0]   err_count;
  logic [W-1:0]  fail_a, fail_b, fail_exp, fail_got;
  logic [3:0]    fail_op;

  alu_181_checker #(.WIDTH(W), .ERR_SAT(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .op_in(op_in), .mode_in(mode_in), .carry_in(carry_in),
    .dut_out(dut_out), .dut_carry(dut_carry), .dut_equal(dut_equal),
    .mismatch(mismatch), .check_count(check_count), .err_count(err_count), .failed(failed),
    .fail_a(fail_a), .fail_b(fail_b), .fail_exp(fail_exp), .fail_got(fail_got),
    .fail_op(fail_op), .fail_mode(fail_mode), .fail_cin(fail_cin)
  );

  typedef struct {
    logic         v;
    logic         fail;
    logic [W-1:0] a, b, exp_r, got;
    logic [3:0]   op;
    logic         mode, cin;
  } ent_t;

  ent_t exp_q[$];

  // Scoreboard model of the checker outputs.
  logic         m_mis, m_failed, m_fmode, m_fcin;
  logic [31:0]  m_chk;
  logic [15:0]  m_err;
  logic [W-1:0] m_fa, m_fb, m_fexp, m_fgot;
  logic [3:0]   m_fop;

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void ref_alu(input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] op, input logic md, input logic ci,
                                  output logic [15:0] r, output logic co, output logic eq);
    logic [15:0] x, y;
    logic [16:0] s;
    x = 16'h0; y = 16'h0; r = 16'h0; co = 1'b0;
    if (md) begin
      case (op)
        4'h0: r = ~a;        4'h1: r = ~(a | b);  4'h2: r = ~a & b;     4'h3: r = 16'h0000;
        4'h4: r = ~(a & b);  4'h5: r = ~b;        4'h6: r = a ^ b;      4'h7: r = a & ~b;
        4'h8: r = ~a | b;    4'h9: r = ~(a ^ b);  4'hA: r = b;          4'hB: r = a & b;
        4'hC: r = 16'hFFFF;  4'hD: r = a | ~b;    4'hE: r = a | b;      default: r = a;
      endcase
    end else begin
      case (op)
        4'h0: begin x = a;      y = 16'h0;    end
        4'h1: begin x = a | b;  y = 16'h0;    end
        4'h2: begin x = a | ~b; y = 16'h0;    end
        4'h3: begin x = 16'h0;  y = 16'hFFFF; end
        4'h4: begin x = a;      y = a & ~b;   end
        4'h5: begin x = a | b;  y = a & ~b;   end
        4'h6: begin x = a;      y = ~b;       end
        4'h7: begin x = a & ~b; y = 16'hFFFF; end
        4'h8: begin x = a;      y = a & b;    end
        4'h9: begin x = a;      y = b;        end
        4'hA: begin x = a | ~b; y = a & b;    end
        4'hB: begin x = a & b;  y = 16'hFFFF; end
        4'hC: begin x = a;      y = a;        end
        4'hD: begin x = a | b;  y = a;        end
        4'hE: begin x = a | ~b; y = a;        end
        default: begin x = a;   y = 16'hFFFF; end
      endcase
      s  = {1'b0, x} + {1'b0, y} + {16'd0, ci};
      r  = s[15:0];
      co = s[16];
    end
    eq = (r == 16'hFFFF);
  endfunction

  // Drive one cycle; the entry pushed now reaches the outputs two edges after sampling.
  task automatic tick(input logic r, input logic c, input logic v,
                      input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                      input logic md, input logic ci,
                      input logic [15:0] dout, input logic dco, input logic deq);
    ent_t e;
    logic [15:0] er;
    logic ec, ee;
    rst = r; clear = c; in_valid = v; a_in = a; b_in = b; op_in = op;
    mode_in = md; carry_in = ci; dut_out = dout; dut_carry = dco; dut_equal = deq;
    ref_alu(a, b, op, md, ci, er, ec, ee);
    e.v = v & ~r & ~c;
    e.fail = (er !== dout) || (ec !== dco) || (ee !== deq);
    e.a = a; e.b = b; e.exp_r = er; e.got = dout; e.op = op; e.mode = md; e.cin = ci;
    if (r || c) begin
      exp_q.delete();
      m_chk = 0; m_err = 0; m_failed = 0; m_fa = 0; m_fb = 0; m_fexp = 0; m_fgot = 0;
      m_fop = 0; m_fmode = 0; m_fcin = 0;
    end
    exp_q.push_back(e);
    @(negedge clk);
    m_mis = 1'b0;
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      if (e.v) begin
        m_chk = m_chk + 32'd1;
        if (e.fail) begin
          m_mis = 1'b1;
          if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
          if (!m_failed) begin
            m_failed = 1'b1; m_fa = e.a; m_fb = e.b; m_fexp = e.exp_r; m_fgot = e.got;
            m_fop = e.op; m_fmode = e.mode; m_fcin = e.cin;
          end
        end
      end
    end
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic vec(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                     input logic md, input logic ci,
                     input logic [15:0] dout, input logic dco, input logic deq);
    tick(1'b0, 1'b0, 1'b1, a, b, op, md, ci, dout, dco, deq);
  endtask

  task automatic test_reset();
    repeat (2) tick(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    n_cmp++; if (mismatch !== 1'b0) begin n_fail++;
      $display("FAIL reset_mismatch: got %b expected 0", mismatch); end
    n_cmp++; if (check_count !== 32'd0) begin n_fail++;
      $display("FAIL reset_check_count: got %0d expected 0", check_count); end
    n_cmp++; if (err_count !== 16'd0) begin n_fail++;
      $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    n_cmp++; if (failed !== 1'b0) begin n_fail++;
      $display("FAIL reset_failed: got %b expected 0", failed); end
    n_cmp++;
    if ({fail_a, fail_b, fail_exp, fail_got, fail_op, fail_mode, fail_cin} !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_capture: got %h/%h/%h/%h/%h/%b/%b expected all 0",
               fail_a, fail_b, fail_exp, fail_got, fail_op, fail_mode, fail_cin);
    end
  endtask

  task automatic test_spec_vectors();
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: vec(16'h0000, 16'h0001, 4'h9, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
        1: vec(16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        2: vec(16'h00FF, 16'hFF00, 4'h6, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1);
        3: vec(16'h00FF, 16'hFF00, 4'h6, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        default: idle();
      endcase
      n_cmp++; if (mismatch !== m_mis) begin n_fail++;
        $display("FAIL spec_mismatch[%0d]: got %b expected %b", i, mismatch, m_mis); end
      n_cmp++; if (check_count !== m_chk) begin n_fail++;
        $display("FAIL spec_check_count[%0d]: got %0d expected %0d", i, check_count, m_chk); end
      n_cmp++; if (err_count !== m_err) begin n_fail++;
        $display("FAIL spec_err_count[%0d]: got %0d expected %0d", i, err_count, m_err); end
      n_cmp++; if (failed !== m_failed) begin n_fail++;
        $display("FAIL spec_failed[%0d]: got %b expected %b", i, failed, m_failed); end
      if (i == 2) begin
        n_cmp++; if ({mismatch, check_count} !== {1'b0, 32'd1}) begin n_fail++;
          $display("FAIL spec_first_check: got %b/%0d expected 0/1", mismatch, check_count); end
      end
      if (i == 3) begin
        n_cmp++; if (mismatch !== 1'b1) begin n_fail++;
          $display("FAIL spec_carry_pulse: got %b expected 1", mismatch); end
      end
    end
    n_cmp++; if (fail_exp !== 16'h0000 || fail_a !== 16'hFFFF || fail_op !== 4'h9) begin
      n_fail++;
      $display("FAIL spec_capture: got exp=%h a=%h op=%h expected 0000/ffff/9",
               fail_exp, fail_a, fail_op); end
    n_cmp++; if ({check_count, err_count} !== {32'd4, 16'd2}) begin n_fail++;
      $display("FAIL spec_counts: got %0d/%0d expected 4/2", check_count, err_count); end
  endtask

  task automatic test_back_to_back();
    tick(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: vec(16'h0001, 16'h0000, 4'hF, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
        1: vec(16'h0002, 16'h0000, 4'hF, 1'b1, 1'b1, 16'h5678, 1'b0, 1'b0);
        default: idle();
      endcase
      n_cmp++; if (mismatch !== m_mis) begin n_fail++;
        $display("FAIL b2b_mismatch[%0d]: got %b expected %b", i, mismatch, m_mis); end
      n_cmp++; if (err_count !== m_err) begin n_fail++;
        $display("FAIL b2b_err_count[%0d]: got %0d expected %0d", i, err_count, m_err); end
    end
    n_cmp++; if (err_count !== 16'd2) begin n_fail++;
      $display("FAIL b2b_err_total: got %0d expected 2", err_count); end
    n_cmp++; if (fail_got !== 16'h1234) begin n_fail++;
      $display("FAIL b2b_fail_got: got %h expected 1234", fail_got); end
  endtask

  task automatic test_random();
    tick(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a, b, d;
      logic [3:0] op;
      logic md, ci, co, eq, v;
      int k;
      v  = ($urandom_range(0, 3) != 0);
      a  = 16'($urandom);
      b  = 16'($urandom);
      if ($urandom_range(0, 4) == 0) a = 16'hFFFF;
      if ($urandom_range(0, 4) == 0) b = 16'h0000;
      op = 4'($urandom);
      md = 1'($urandom);
      ci = 1'($urandom);
      ref_alu(a, b, op, md, ci, d, co, eq);
      k = $urandom_range(0, 15);
      if (k == 0) d = d ^ (16'h0001 << $urandom_range(0, 15));
      else if (k == 1) co = ~co;
      else if (k == 2) eq = ~eq;
      tick(1'b0, 1'b0, v, a, b, op, md, ci, d, co, eq);
      n_cmp++; if (mismatch !== m_mis) begin n_fail++;
        $display("FAIL rnd_mismatch[%0d]: got %b expected %b (op %h mode %b)",
                 i, mismatch, m_mis, op, md); end
      n_cmp++; if (check_count !== m_chk) begin n_fail++;
        $display("FAIL rnd_check_count[%0d]: got %0d expected %0d", i, check_count, m_chk); end
      n_cmp++; if (err_count !== m_err) begin n_fail++;
        $display("FAIL rnd_err_count[%0d]: got %0d expected %0d", i, err_count, m_err); end
      n_cmp++; if (failed !== m_failed) begin n_fail++;
        $display("FAIL rnd_failed[%0d]: got %b expected %b", i, failed, m_failed); end
    end
    n_cmp++;
    if ({fail_a, fail_b, fail_exp, fail_got, fail_op, fail_mode, fail_cin} !==
        {m_fa, m_fb, m_fexp, m_fgot, m_fop, m_fmode, m_fcin}) begin
      n_fail++;
      $display("FAIL rnd_capture: got %h/%h/%h/%h/%h/%b/%b expected %h/%h/%h/%h/%h/%b/%b",
               fail_a, fail_b, fail_exp, fail_got, fail_op, fail_mode, fail_cin,
               m_fa, m_fb, m_fexp, m_fgot, m_fop, m_fmode, m_fcin);
    end
  endtask

  task automatic test_rst_midstream();
    vec(16'h0010, 16'h0000, 4'hF, 1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) vec(16'h0003, 16'h0004, 4'h9, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
      else idle();
      n_cmp++; if (mismatch !== 1'b0) begin n_fail++;
        $display("FAIL rst_mid_mismatch[%0d]: got %b expected 0", i, mismatch); end
      n_cmp++; if (check_count !== m_chk) begin n_fail++;
        $display("FAIL rst_mid_check_count[%0d]: got %0d expected %0d", i, check_count, m_chk);
      end
      n_cmp++;
      if ({err_count, failed, fail_a, fail_got, fail_op} !== 53'd0) begin n_fail++;
        $display("FAIL rst_mid_outputs[%0d]: got %0d/%b/%h/%h/%h expected all 0",
                 i, err_count, failed, fail_a, fail_got, fail_op); end
    end
    n_cmp++; if (check_count !== 32'd1) begin n_fail++;
      $display("FAIL rst_mid_post_check: got %0d expected 1", check_count); end
  endtask

  task automatic test_saturation();
    tick(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++)
      vec(16'(i), 16'h0000, 4'h3, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    n_cmp++; if (err_count !== 16'hFFFF || err_count !== m_err) begin n_fail++;
      $display("FAIL sat_err_count: got %h expected ffff", err_count); end
    n_cmp++; if (check_count !== m_chk) begin n_fail++;
      $display("FAIL sat_check_count: got %0d expected %0d", check_count, m_chk); end
    n_cmp++; if (failed !== 1'b1 || fail_a !== 16'h0000) begin n_fail++;
      $display("FAIL sat_capture: got failed=%b a=%h expected 1/0000", failed, fail_a); end
    // Clear lands while a failing check sits in stage 2; it must not be counted.
    tick(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({mismatch, check_count, err_count, failed, fail_got} !== 66'd0) begin n_fail++;
        $display("FAIL sat_clear[%0d]: got %b/%0d/%0d/%b/%h expected all 0",
                 i, mismatch, check_count, err_count, failed, fail_got); end
      idle();
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; op_in = '0;
    mode_in = 1'b0; carry_in = 1'b0; dut_out = '0; dut_carry = 1'b0; dut_equal = 1'b0;
    m_mis = 0; m_chk = 0; m_err = 0; m_failed = 0; m_fa = 0; m_fb = 0; m_fexp = 0;
    m_fgot = 0; m_fop = 0; m_fmode = 0; m_fcin = 0;
    test_reset();
    test_spec_vectors();
    test_back_to_back();
    test_random();
    test_rst_midstream();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
